// File: rtl/bomb_controller_if.sv
// Signal bundle between the bomb engine and the game core: player/pixel inputs,
// bomb/explosion render outputs, exploding tile and the sticky death flag.
interface bomb_controller_if;
  logic        C;
  logic [9:0]  b_x;
  logic [9:0]  b_y;
  logic [9:0]  v_x;
  logic [9:0]  v_y;
  logic        bomb_on;
  logic [11:0] bomb_rgb;
  logic        explosion_on;
  logic [11:0] explosion_rgb;
  logic        exploding;
  logic [4:0]  bomb_tx;
  logic [3:0]  bomb_ty;
  logic        game_over;

  modport master (
    output C, b_x, b_y, v_x, v_y,
    input  bomb_on, bomb_rgb, explosion_on, explosion_rgb, exploding,
           bomb_tx, bomb_ty, game_over
  );

  modport slave (
    input  C, b_x, b_y, v_x, v_y,
    output bomb_on, bomb_rgb, explosion_on, explosion_rgb, exploding,
           bomb_tx, bomb_ty, game_over
  );
endinterface

// File: rtl/bomb_controller.sv
// Single-bomb placement, fuse and explosion engine: places a bomb on the
// player's tile, detonates it after a fuse, renders bomb/cross and flags death.
module bomb_controller #(
  parameter int X_ORIGIN       = 144,
  parameter int Y_ORIGIN       = 35,
  parameter int TILE_LOG2      = 5,
  parameter int GRID_W         = 20,
  parameter int GRID_H         = 15,
  parameter int FUSE_CYCLES    = 300000000,
  parameter int EXPLODE_CYCLES = 50000000,
  parameter int RANGE          = 1
) (
  input logic               clk,
  input logic               reset,
  bomb_controller_if.slave  bus
);

  localparam int HALF = 1 << (TILE_LOG2 - 1);
  localparam int TILE = 1 << TILE_LOG2;
  localparam logic [28:0] FUSE_LAST = 29'(FUSE_CYCLES - 1);
  localparam logic [28:0] EXPL_LAST = 29'(EXPLODE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODE} state_t;

  state_t      state;
  logic [28:0] counter;
  logic [4:0]  bomb_tx;
  logic [3:0]  bomb_ty;
  logic        game_over;
  logic        c_prev;

  logic        press;
  logic [9:0]  bx_c, by_c;
  logic [4:0]  btx;
  logic [3:0]  bty;
  logic [9:0]  px, py, ptx, pty, off_x, off_y;
  logic        pix_valid;
  logic        man_hit;

  // Tile-distance test against the bomb's cross; inputs are wide so that
  // out-of-range pixel tiles never alias onto the bomb's row or column.
  function automatic logic in_cross(input logic [9:0] tx, input logic [9:0] ty,
                                    input logic [4:0] cx, input logic [3:0] cy);
    logic [9:0] ex, ey, dx, dy;
    ex = {5'b0, cx};
    ey = {6'b0, cy};
    dx = (tx >= ex) ? tx - ex : ex - tx;
    dy = (ty >= ey) ? ty - ey : ey - ty;
    return ((ty == ey) && (dx <= 10'(RANGE))) || ((tx == ex) && (dy <= 10'(RANGE)));
  endfunction

  assign press = bus.C & ~c_prev;

  // Player tile is taken from the sprite centre.
  assign bx_c = bus.b_x + 10'(HALF) - 10'(X_ORIGIN);
  assign by_c = bus.b_y + 10'(HALF) - 10'(Y_ORIGIN);
  assign btx  = 5'(bx_c >> TILE_LOG2);
  assign bty  = 4'(by_c >> TILE_LOG2);

  assign px    = bus.v_x - 10'(X_ORIGIN);
  assign py    = bus.v_y - 10'(Y_ORIGIN);
  assign ptx   = px >> TILE_LOG2;
  assign pty   = py >> TILE_LOG2;
  assign off_x = px & 10'(TILE - 1);
  assign off_y = py & 10'(TILE - 1);
  assign pix_valid = (bus.v_x >= 10'(X_ORIGIN)) && (bus.v_y >= 10'(Y_ORIGIN)) &&
                     (ptx < 10'(GRID_W)) && (pty < 10'(GRID_H));

  assign man_hit = in_cross({5'b0, btx}, {6'b0, bty}, bomb_tx, bomb_ty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      bomb_tx   <= '0;
      bomb_ty   <= '0;
      game_over <= 1'b0;
      c_prev    <= 1'b0;
    end else begin
      c_prev <= bus.C;
      case (state)
        IDLE: begin
          if (press && !game_over) begin
            bomb_tx <= btx;
            bomb_ty <= bty;
            counter <= '0;
            state   <= ARMED;
          end
        end
        ARMED: begin
          if (counter == FUSE_LAST) begin
            counter <= '0;
            state   <= EXPLODE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        EXPLODE: begin
          if (man_hit) game_over <= 1'b1;
          if (counter == EXPL_LAST) begin
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bomb_on = (state == ARMED) && pix_valid &&
                       (ptx == {5'b0, bomb_tx}) && (pty == {6'b0, bomb_ty}) &&
                       (off_x >= 10'd4) && (off_x <= 10'(TILE - 5)) &&
                       (off_y >= 10'd4) && (off_y <= 10'(TILE - 5));
  assign bus.explosion_on  = (state == EXPLODE) && pix_valid &&
                             in_cross(ptx, pty, bomb_tx, bomb_ty);
  assign bus.bomb_rgb      = 12'h222;
  assign bus.explosion_rgb = 12'hF80;
  assign bus.exploding     = (state == EXPLODE);
  assign bus.bomb_tx       = bomb_tx;
  assign bus.bomb_ty       = bomb_ty;
  assign bus.game_over     = game_over;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller with a short fuse/explosion: pixel vector
// table per phase plus hand-written placement, hold, busy, death and reset sequences.
module tb_bomb_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  bomb_controller_if bus ();

  bomb_controller #(
    .FUSE_CYCLES   (10),
    .EXPLODE_CYCLES(5),
    .RANGE         (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         phase;
    logic [9:0] vx;
    logic [9:0] vy;
    logic       bomb;
    logic       expl;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int ph, input int vx, input int vy, input logic b,
                     input logic e, input string name);
    vec_t v;
    v.phase = ph; v.vx = 10'(vx); v.vy = 10'(vy); v.bomb = b; v.expl = e; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        bus.v_x = vecs[i].vx;
        bus.v_y = vecs[i].vy;
        #1;
        check({vecs[i].name, " bomb_on"}, 32'(bus.bomb_on), 32'(vecs[i].bomb));
        check({vecs[i].name, " explosion_on"}, 32'(bus.explosion_on), 32'(vecs[i].expl));
      end
    end
  endtask

  task automatic wait_expl(input logic lvl, input string name);
    int n;
    n = 0;
    while (bus.exploding !== lvl && n < 40) begin
      tick();
      n++;
    end
    if (bus.exploding !== lvl) begin
      tests++;
      fails++;
      $display("FAIL %s: exploding stuck at %0b, wanted %0b", name, bus.exploding, lvl);
    end
  endtask

  int t_armed, t_expl, rises;
  logic prev;

  initial begin
    // phase 0: ARMED, bomb at tile (1,1) whose top-left pixel is (176,67)
    add(0, 192, 83, 1'b1, 1'b0, "armed centre");
    add(0, 177, 68, 1'b0, 1'b0, "armed corner");
    add(0, 180, 71, 1'b1, 1'b0, "armed inset 4");
    add(0, 203, 94, 1'b1, 1'b0, "armed inset 27");
    add(0, 204, 83, 1'b0, 1'b0, "armed offset 28");
    add(0, 179, 83, 1'b0, 1'b0, "armed offset 3");
    // phase 1: EXPLODE, bomb at (1,1); tile centre = (160+32tx, 51+32ty)
    add(1, 160, 83, 1'b0, 1'b1, "expl tile 0,1");
    add(1, 224, 83, 1'b0, 1'b1, "expl tile 2,1");
    add(1, 192, 51, 1'b0, 1'b1, "expl tile 1,0");
    add(1, 192, 115, 1'b0, 1'b1, "expl tile 1,2");
    add(1, 192, 83, 1'b0, 1'b1, "expl tile 1,1");
    add(1, 224, 115, 1'b0, 1'b0, "expl tile 2,2");
    add(1, 256, 83, 1'b0, 1'b0, "expl tile 3,1");
    // phase 2: EXPLODE, bomb at (0,0), arms clipped by the grid edge
    add(2, 140, 51, 1'b0, 1'b0, "clip vx 140");
    add(2, 160, 30, 1'b0, 1'b0, "clip vy 30");
    add(2, 160, 51, 1'b0, 1'b1, "edge tile 0,0");
    add(2, 192, 51, 1'b0, 1'b1, "edge tile 1,0");
    add(2, 160, 83, 1'b0, 1'b1, "edge tile 0,1");
    add(2, 224, 51, 1'b0, 1'b0, "edge tile 2,0");

    bus.C = 1'b0; bus.b_x = '0; bus.b_y = '0; bus.v_x = 10'd192; bus.v_y = 10'd83;
    reset = 1'b1;
    repeat (2) tick();
    check("reset bomb_on", 32'(bus.bomb_on), 0);
    check("reset explosion_on", 32'(bus.explosion_on), 0);
    check("reset exploding", 32'(bus.exploding), 0);
    check("reset game_over", 32'(bus.game_over), 0);
    check("reset bomb_tx", 32'(bus.bomb_tx), 0);
    check("reset bomb_ty", 32'(bus.bomb_ty), 0);
    check("bomb_rgb", 32'(bus.bomb_rgb), 32'h222);
    check("explosion_rgb", 32'(bus.explosion_rgb), 32'hF80);
    reset = 1'b0;
    tick();

    // placement, fuse timing, cross shape and death with the player on the bomb
    bus.b_x = 10'd176; bus.b_y = 10'd67; bus.C = 1'b1;
    tick();
    bus.C = 1'b0;
    t_armed = cyc;
    check("place bomb_tx", 32'(bus.bomb_tx), 1);
    check("place bomb_ty", 32'(bus.bomb_ty), 1);
    check("armed not exploding", 32'(bus.exploding), 0);
    apply_phase(0);
    wait_expl(1'b1, "fuse rise");
    check("fuse length", 32'(cyc - t_armed), 10);
    t_expl = cyc;
    apply_phase(1);
    tick();
    check("death game_over", 32'(bus.game_over), 1);
    wait_expl(1'b0, "explode fall");
    check("explode length", 32'(cyc - t_expl), 5);
    check("game_over sticky", 32'(bus.game_over), 1);

    // press after death is ignored
    bus.b_x = 10'd240; bus.C = 1'b1;
    tick();
    bus.C = 1'b0;
    repeat (2) tick();
    bus.v_x = 10'd192; bus.v_y = 10'd83;
    #1;
    check("dead press exploding", 32'(bus.exploding), 0);
    check("dead press bomb_on", 32'(bus.bomb_on), 0);
    check("dead press bomb_tx", 32'(bus.bomb_tx), 1);
    check("dead game_over", 32'(bus.game_over), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("game_over cleared", 32'(bus.game_over), 0);

    // held button: one bomb at (0,0), player walks to safe tile (3,0)
    bus.b_x = 10'd144; bus.b_y = 10'd35; bus.C = 1'b1;
    tick();
    bus.b_x = 10'd240;
    check("held bomb_tx", 32'(bus.bomb_tx), 0);
    check("held bomb_ty", 32'(bus.bomb_ty), 0);
    rises = 0;
    prev = bus.exploding;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (bus.exploding && !prev) begin
        rises++;
        apply_phase(2);
      end
      prev = bus.exploding;
    end
    check("held one bomb cycle", 32'(rises), 1);
    check("held idle at end", 32'(bus.exploding), 0);
    check("held no re-latch", 32'(bus.bomb_tx), 0);
    check("safe game_over", 32'(bus.game_over), 0);
    bus.C = 1'b0;
    tick();

    // busy: second press while ARMED does not move the bomb
    bus.b_x = 10'd240; bus.b_y = 10'd35; bus.C = 1'b1;
    tick();
    bus.C = 1'b0;
    check("busy first bomb_tx", 32'(bus.bomb_tx), 3);
    bus.b_x = 10'd336; bus.b_y = 10'd99;
    repeat (2) tick();
    bus.C = 1'b1;
    tick();
    bus.C = 1'b0;
    tick();
    check("busy bomb_tx kept", 32'(bus.bomb_tx), 3);
    check("busy bomb_ty kept", 32'(bus.bomb_ty), 0);
    check("busy still armed", 32'(bus.exploding), 0);
    wait_expl(1'b1, "busy rise");
    wait_expl(1'b0, "busy fall");
    check("busy safe game_over", 32'(bus.game_over), 0);

    // asynchronous reset three cycles into EXPLODE
    bus.b_x = 10'd176; bus.b_y = 10'd67; bus.C = 1'b1;
    tick();
    bus.C = 1'b0;
    wait_expl(1'b1, "async rise");
    repeat (3) tick();
    bus.v_x = 10'd192; bus.v_y = 10'd83;
    #1;
    check("pre-reset explosion_on", 32'(bus.explosion_on), 1);
    check("pre-reset game_over", 32'(bus.game_over), 1);
    reset = 1'b1;
    #1;
    check("async exploding", 32'(bus.exploding), 0);
    check("async explosion_on", 32'(bus.explosion_on), 0);
    check("async game_over", 32'(bus.game_over), 0);
    check("async bomb_tx", 32'(bus.bomb_tx), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
